// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes and the "no register" index.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] STAT_AOK = 4'h8;
  localparam logic [3:0] STAT_HLT = 4'h4;
  localparam logic [3:0] STAT_ADR = 4'h2;
  localparam logic [3:0] STAT_INS = 4'h1;

  // All-ones register index marks "no register" for a given index width.
  function automatic int unsigned rnone(input int unsigned ridx_w);
    return (32'd1 << ridx_w) - 32'd1;
  endfunction

endpackage

// File: rtl/y86_regfile.sv
// NREGS x XLEN register file: two synchronous write ports (M wins on collision),
// three combinational read ports (A, B, debug), synchronous reset with stack preset.
module y86_regfile
  import y86_pkg::*;
#(
  parameter int unsigned           XLEN     = 64,
  parameter int unsigned           NREGS    = 15,
  parameter int unsigned           RIDX_W   = 4,
  parameter int unsigned           RSP_IDX  = 4,
  parameter logic [XLEN-1:0]       RSP_INIT = XLEN'(256)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_e,
  input  logic [RIDX_W-1:0] i_wr_e_idx,
  input  logic [XLEN-1:0]   i_wr_e_val,
  input  logic              i_wr_m,
  input  logic [RIDX_W-1:0] i_wr_m_idx,
  input  logic [XLEN-1:0]   i_wr_m_val,
  input  logic [RIDX_W-1:0] i_rd_a_idx,
  output logic [XLEN-1:0]   o_rd_a_val,
  input  logic [RIDX_W-1:0] i_rd_b_idx,
  output logic [XLEN-1:0]   o_rd_b_val,
  input  logic [RIDX_W-1:0] i_rd_dbg_idx,
  output logic [XLEN-1:0]   o_rd_dbg_val
);

  localparam logic [RIDX_W-1:0] RNONE    = RIDX_W'(rnone(RIDX_W));
  localparam int unsigned       NPORTS   = 3;

  logic [XLEN-1:0]   r_regs [NREGS];
  logic [RIDX_W-1:0] w_idx  [NPORTS];
  logic [XLEN-1:0]   w_rd   [NPORTS];

  // Reset dominates any write pending in the same cycle.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (reset) begin
        r_regs[i] <= (i == RSP_IDX) ? RSP_INIT : '0;
      end else if (i_wr_m && i_wr_m_idx != RNONE && i_wr_m_idx == RIDX_W'(i)) begin
        r_regs[i] <= i_wr_m_val;
      end else if (i_wr_e && i_wr_e_idx != RNONE && i_wr_e_idx == RIDX_W'(i)) begin
        r_regs[i] <= i_wr_e_val;
      end
    end
  end

  assign w_idx[0] = i_rd_a_idx;
  assign w_idx[1] = i_rd_b_idx;
  assign w_idx[2] = i_rd_dbg_idx;

  // Unmatched indices (RNONE or beyond NREGS) read as zero.
  always_comb begin
    for (int unsigned p = 0; p < NPORTS; p++) begin
      w_rd[p] = '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (w_idx[p] != RNONE && w_idx[p] == RIDX_W'(i)) begin
          w_rd[p] = r_regs[i];
        end
      end
    end
  end

  assign o_rd_a_val   = w_rd[0];
  assign o_rd_b_val   = w_rd[1];
  assign o_rd_dbg_val = w_rd[2];

endmodule

// File: rtl/decode_stage_param.sv
// Y86-64 decode stage: source/destination decode, register read with six-way
// forwarding, writeback into the register file and the D->E pipeline register.
module decode_stage_param
  import y86_pkg::*;
#(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     NREGS    = 15,
  parameter int unsigned     RIDX_W   = 4,
  parameter int unsigned     RSP_IDX  = 4,
  parameter logic [XLEN-1:0] RSP_INIT = XLEN'(256)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        D_icode,
  input  logic [3:0]        D_ifun,
  input  logic [RIDX_W-1:0] D_rA,
  input  logic [RIDX_W-1:0] D_rB,
  input  logic [XLEN-1:0]   D_valC,
  input  logic [XLEN-1:0]   D_valP,
  input  logic [3:0]        D_stat,
  input  logic [RIDX_W-1:0] e_dstE,
  input  logic [XLEN-1:0]   e_valE,
  input  logic [RIDX_W-1:0] M_dstE,
  input  logic [XLEN-1:0]   M_valE,
  input  logic [RIDX_W-1:0] M_dstM,
  input  logic [XLEN-1:0]   m_valM,
  input  logic [RIDX_W-1:0] W_dstE,
  input  logic [XLEN-1:0]   W_valE,
  input  logic [RIDX_W-1:0] W_dstM,
  input  logic [XLEN-1:0]   W_valM,
  input  logic              W_wrE,
  input  logic              W_wrM,
  input  logic              E_stall,
  input  logic              E_bubble,
  input  logic [RIDX_W-1:0] dbg_idx,
  output logic [XLEN-1:0]   dbg_val,
  output logic [RIDX_W-1:0] d_srcA,
  output logic [RIDX_W-1:0] d_srcB,
  output logic              load_use,
  output logic [3:0]        E_icode,
  output logic [3:0]        E_ifun,
  output logic [XLEN-1:0]   E_valA,
  output logic [XLEN-1:0]   E_valB,
  output logic [XLEN-1:0]   E_valC,
  output logic [RIDX_W-1:0] E_srcA,
  output logic [RIDX_W-1:0] E_srcB,
  output logic [RIDX_W-1:0] E_dstE,
  output logic [RIDX_W-1:0] E_dstM,
  output logic [3:0]        E_stat
);

  localparam logic [RIDX_W-1:0] RNONE = RIDX_W'(rnone(RIDX_W));
  localparam logic [RIDX_W-1:0] RSP   = RIDX_W'(RSP_IDX);

  logic [RIDX_W-1:0] w_srcA, w_srcB, w_dstE, w_dstM;
  logic [XLEN-1:0]   w_rf_a, w_rf_b;
  logic [XLEN-1:0]   w_valA, w_valB;

  logic [3:0]        r_icode, r_ifun, r_stat;
  logic [XLEN-1:0]   r_valA, r_valB, r_valC;
  logic [RIDX_W-1:0] r_srcA, r_srcB, r_dstE, r_dstM;

  function automatic logic hit(input logic [RIDX_W-1:0] src, input logic [RIDX_W-1:0] dst);
    return (src != RNONE) && (dst != RNONE) && (src == dst);
  endfunction

  // Register-field selection per instruction; unused fields stay RNONE.
  always_comb begin
    w_srcA = RNONE;
    w_srcB = RNONE;
    w_dstE = RNONE;
    w_dstM = RNONE;
    case (D_icode)
      I_RRMOVQ: begin w_srcA = D_rA; w_dstE = D_rB; end
      I_IRMOVQ: begin w_dstE = D_rB; end
      I_RMMOVQ: begin w_srcA = D_rA; w_srcB = D_rB; end
      I_MRMOVQ: begin w_srcB = D_rB; w_dstM = D_rA; end
      I_OPQ:    begin w_srcA = D_rA; w_srcB = D_rB; w_dstE = D_rB; end
      I_CALL:   begin w_srcB = RSP;  w_dstE = RSP; end
      I_RET:    begin w_srcA = RSP;  w_srcB = RSP;  w_dstE = RSP; end
      I_PUSHQ:  begin w_srcA = D_rA; w_srcB = RSP;  w_dstE = RSP; end
      I_POPQ:   begin w_srcA = RSP;  w_srcB = RSP;  w_dstE = RSP; w_dstM = D_rA; end
      default:  begin end
    endcase
  end

  y86_regfile #(
    .XLEN     (XLEN),
    .NREGS    (NREGS),
    .RIDX_W   (RIDX_W),
    .RSP_IDX  (RSP_IDX),
    .RSP_INIT (RSP_INIT)
  ) u_regfile (
    .clk          (clk),
    .reset        (reset),
    .i_wr_e       (W_wrE),
    .i_wr_e_idx   (W_dstE),
    .i_wr_e_val   (W_valE),
    .i_wr_m       (W_wrM),
    .i_wr_m_idx   (W_dstM),
    .i_wr_m_val   (W_valM),
    .i_rd_a_idx   (w_srcA),
    .o_rd_a_val   (w_rf_a),
    .i_rd_b_idx   (w_srcB),
    .o_rd_b_val   (w_rf_b),
    .i_rd_dbg_idx (dbg_idx),
    .o_rd_dbg_val (dbg_val)
  );

  // Youngest producer wins; jumps and calls carry valP through valA.
  always_comb begin
    w_valA = w_rf_a;
    if (D_icode == I_JXX || D_icode == I_CALL) w_valA = D_valP;
    else if (hit(w_srcA, e_dstE))              w_valA = e_valE;
    else if (hit(w_srcA, M_dstM))              w_valA = m_valM;
    else if (hit(w_srcA, M_dstE))              w_valA = M_valE;
    else if (hit(w_srcA, W_dstM))              w_valA = W_valM;
    else if (hit(w_srcA, W_dstE))              w_valA = W_valE;
  end

  always_comb begin
    w_valB = w_rf_b;
    if (hit(w_srcB, e_dstE))      w_valB = e_valE;
    else if (hit(w_srcB, M_dstM)) w_valB = m_valM;
    else if (hit(w_srcB, M_dstE)) w_valB = M_valE;
    else if (hit(w_srcB, W_dstM)) w_valB = W_valM;
    else if (hit(w_srcB, W_dstE)) w_valB = W_valE;
  end

  // E register: bubble takes precedence over stall.
  always_ff @(posedge clk) begin
    if (reset || E_bubble) begin
      r_icode <= I_NOP;
      r_ifun  <= 4'h0;
      r_valA  <= '0;
      r_valB  <= '0;
      r_valC  <= '0;
      r_srcA  <= RNONE;
      r_srcB  <= RNONE;
      r_dstE  <= RNONE;
      r_dstM  <= RNONE;
      r_stat  <= STAT_AOK;
    end else if (!E_stall) begin
      r_icode <= D_icode;
      r_ifun  <= D_ifun;
      r_valA  <= w_valA;
      r_valB  <= w_valB;
      r_valC  <= D_valC;
      r_srcA  <= w_srcA;
      r_srcB  <= w_srcB;
      r_dstE  <= w_dstE;
      r_dstM  <= w_dstM;
      r_stat  <= D_stat;
    end
  end

  assign load_use = (r_icode == I_MRMOVQ || r_icode == I_POPQ) && (r_dstM != RNONE) &&
                    (r_dstM == w_srcA || r_dstM == w_srcB);

  assign d_srcA  = w_srcA;
  assign d_srcB  = w_srcB;
  assign E_icode = r_icode;
  assign E_ifun  = r_ifun;
  assign E_valA  = r_valA;
  assign E_valB  = r_valB;
  assign E_valC  = r_valC;
  assign E_srcA  = r_srcA;
  assign E_srcB  = r_srcB;
  assign E_dstE  = r_dstE;
  assign E_dstM  = r_dstM;
  assign E_stat  = r_stat;

endmodule

// File: tb/tb_decode_stage_param.sv
// Scoreboard bench for decode_stage_param: directed scenarios plus random traffic
// checked against an instruction-level model of the register file and E register.
module tb_decode_stage_param;

  logic        clk, reset;
  logic [3:0]  D_icode, D_ifun, D_stat;
  logic [3:0]  D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic        W_wrE, W_wrM, E_stall, E_bubble;
  logic [3:0]  dbg_idx;
  logic [63:0] dbg_val;
  logic [3:0]  d_srcA, d_srcB;
  logic        load_use;
  logic [3:0]  E_icode, E_ifun, E_stat;
  logic [63:0] E_valA, E_valB, E_valC;
  logic [3:0]  E_srcA, E_srcB, E_dstE, E_dstM;

  decode_stage_param dut (
    .clk(clk), .reset(reset),
    .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP), .D_stat(D_stat),
    .e_dstE(e_dstE), .e_valE(e_valE), .M_dstE(M_dstE), .M_valE(M_valE),
    .M_dstM(M_dstM), .m_valM(m_valM), .W_dstE(W_dstE), .W_valE(W_valE),
    .W_dstM(W_dstM), .W_valM(W_valM), .W_wrE(W_wrE), .W_wrM(W_wrM),
    .E_stall(E_stall), .E_bubble(E_bubble), .dbg_idx(dbg_idx), .dbg_val(dbg_val),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .load_use(load_use),
    .E_icode(E_icode), .E_ifun(E_ifun), .E_valA(E_valA), .E_valB(E_valB),
    .E_valC(E_valC), .E_srcA(E_srcA), .E_srcB(E_srcB), .E_dstE(E_dstE),
    .E_dstM(E_dstM), .E_stat(E_stat)
  );

  typedef struct {
    logic [3:0]  icode, ifun, stat;
    logic [63:0] valA, valB, valC;
    logic [3:0]  srcA, srcB, dstE, dstM;
  } e_t;

  localparam logic [3:0] NONE = 4'hF;

  int          checks = 0;
  int          errors = 0;
  e_t          exp_q[$];
  e_t          me;
  logic [63:0] mregs [15];
  bit          model_valid = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Operand usage by instruction class, straight from the ISA definition.
  function automatic logic [3:0] m_srcA(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'h9, 4'hB}) return 4'd4;
    return NONE;
  endfunction
  function automatic logic [3:0] m_srcB(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
    return NONE;
  endfunction
  function automatic logic [3:0] m_dstE(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
    return NONE;
  endfunction
  function automatic logic [3:0] m_dstM(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h5, 4'hB}) return ra;
    return NONE;
  endfunction

  function automatic logic [63:0] m_read(input logic [3:0] idx);
    return (idx < 4'd15) ? mregs[idx] : 64'd0;
  endfunction

  // Newest in-flight value for a source register, else committed state.
  function automatic logic [63:0] m_operand(input logic [3:0] src);
    if (src == NONE)   return 64'd0;
    if (src == e_dstE) return e_valE;
    if (src == M_dstM) return m_valM;
    if (src == M_dstE) return M_valE;
    if (src == W_dstM) return W_valM;
    if (src == W_dstE) return W_valE;
    return m_read(src);
  endfunction

  function automatic e_t bubble_e();
    e_t b;
    b.icode = 4'h1; b.ifun = 4'h0; b.stat = 4'h8;
    b.valA = 64'd0; b.valB = 64'd0; b.valC = 64'd0;
    b.srcA = NONE; b.srcB = NONE; b.dstE = NONE; b.dstM = NONE;
    return b;
  endfunction

  // One clock of stimulus: inputs already applied at a negedge.
  task automatic cycle();
    e_t          nx;
    logic [3:0]  sa, sb;
    logic        lu;
    sa = m_srcA(D_icode, D_rA);
    sb = m_srcB(D_icode, D_rB);
    #1;
    if (model_valid) begin
      lu = (me.icode == 4'h5 || me.icode == 4'hB) && me.dstM != NONE &&
           (me.dstM == sa || me.dstM == sb);
      chk("d_srcA", 64'(d_srcA), 64'(sa));
      chk("d_srcB", 64'(d_srcB), 64'(sb));
      chk("dbg_val", dbg_val, m_read(dbg_idx));
      chk("load_use", 64'(load_use), 64'(lu));
    end
    if (reset || E_bubble) nx = bubble_e();
    else if (E_stall) nx = me;
    else begin
      nx.icode = D_icode; nx.ifun = D_ifun; nx.stat = D_stat; nx.valC = D_valC;
      nx.srcA = sa; nx.srcB = sb;
      nx.dstE = m_dstE(D_icode, D_rB); nx.dstM = m_dstM(D_icode, D_rA);
      nx.valA = (D_icode == 4'h7 || D_icode == 4'h8) ? D_valP : m_operand(sa);
      nx.valB = m_operand(sb);
    end
    exp_q.push_back(nx);
    me = nx;
    if (reset) begin
      for (int i = 0; i < 15; i++) mregs[i] = (i == 4) ? 64'd256 : 64'd0;
      model_valid = 1;
    end else begin
      if (W_wrE && W_dstE < 4'd15) mregs[W_dstE] = W_valE;
      if (W_wrM && W_dstM < 4'd15) mregs[W_dstM] = W_valM;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    reset = 0; D_icode = 4'h1; D_ifun = 0; D_rA = NONE; D_rB = NONE;
    D_valC = 0; D_valP = 0; D_stat = 4'h8;
    e_dstE = NONE; M_dstE = NONE; M_dstM = NONE; W_dstE = NONE; W_dstM = NONE;
    e_valE = 0; M_valE = 0; m_valM = 0; W_valE = 0; W_valM = 0;
    W_wrE = 0; W_wrM = 0; E_stall = 0; E_bubble = 0; dbg_idx = 0;
  endtask

  function automatic logic [3:0] rnd_idx();
    int unsigned r;
    r = $urandom_range(0, 7);
    if (r < 5) return 4'(r);
    if (r == 5) return NONE;
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Monitor: E register is presented every cycle; compare after each edge.
  initial begin
    e_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("E_icode", 64'(E_icode), 64'(e.icode));
        chk("E_ifun",  64'(E_ifun),  64'(e.ifun));
        chk("E_stat",  64'(E_stat),  64'(e.stat));
        chk("E_valA",  E_valA, e.valA);
        chk("E_valB",  E_valB, e.valB);
        chk("E_valC",  E_valC, e.valC);
        chk("E_srcA",  64'(E_srcA), 64'(e.srcA));
        chk("E_srcB",  64'(E_srcB), 64'(e.srcB));
        chk("E_dstE",  64'(E_dstE), 64'(e.dstE));
        chk("E_dstM",  64'(E_dstM), 64'(e.dstM));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset = 1;
    cycle();
    cycle();
    reset = 0;

    // Post-reset state: only the stack pointer is non-zero.
    for (int i = 0; i < 16; i++) begin
      dbg_idx = 4'(i);
      #1 chk("rst_dbg", dbg_val, (i == 4) ? 64'd256 : 64'd0);
      cycle();
    end
    chk("rst_E_icode", 64'(E_icode), 64'h1);
    chk("rst_E_stat", 64'(E_stat), 64'h8);

    // Committed write then read through the register file.
    W_wrE = 1; W_dstE = 4'd2; W_valE = 64'd101;
    cycle();
    idle_inputs();
    D_icode = 4'h6; D_rA = 4'd2; D_rB = 4'd3;
    cycle();
    chk("rf_valA", E_valA, 64'd101);
    chk("rf_valB", E_valB, 64'd0);
    chk("rf_dstE", 64'(E_dstE), 64'd3);

    // Forwarding priority: execute beats memory beats writeback.
    D_icode = 4'h6; D_rA = 4'd1; D_rB = 4'd3;
    e_dstE = 4'd1; e_valE = 64'd7; M_dstM = 4'd1; m_valM = 64'd9;
    W_dstE = 4'd1; W_valE = 64'd11;
    cycle();
    chk("fwd_e", E_valA, 64'd7);
    e_dstE = NONE;
    cycle();
    chk("fwd_m", E_valA, 64'd9);

    // call: valA carries valP, valB forwarded stack pointer.
    idle_inputs();
    D_icode = 4'h8; D_valP = 64'h40; e_dstE = 4'd4; e_valE = 64'd248;
    cycle();
    chk("call_valA", E_valA, 64'h40);
    chk("call_valB", E_valB, 64'd248);
    chk("call_dstE", 64'(E_dstE), 64'd4);

    // Load/use: mrmov into r6 followed by rmmov reading r6.
    idle_inputs();
    D_icode = 4'h5; D_rA = 4'd6; D_rB = NONE;
    cycle();
    D_icode = 4'h4; D_rA = 4'd6; D_rB = 4'd7;
    #1 chk("load_use_hit", 64'(load_use), 64'd1);
    E_bubble = 1; E_stall = 1;
    cycle();
    chk("bub_icode", 64'(E_icode), 64'h1);
    chk("bub_dstE", 64'(E_dstE), 64'(NONE));

    // popq %rsp: memory write wins the collision; index 15 writes vanish.
    idle_inputs();
    W_wrE = 1; W_wrM = 1; W_dstE = 4'd4; W_dstM = 4'd4; W_valE = 64'd264; W_valM = 64'd77;
    cycle();
    idle_inputs();
    dbg_idx = 4'd4;
    #1 chk("pop_rsp", dbg_val, 64'd77);
    W_wrE = 1; W_wrM = 1; W_dstE = NONE; W_dstM = NONE; W_valE = 64'd5; W_valM = 64'd6;
    cycle();
    idle_inputs();
    dbg_idx = 4'd15;
    #1 chk("idx15_read", dbg_val, 64'd0);
    dbg_idx = 4'd4;
    #1 chk("idx15_nowr", dbg_val, 64'd77);
    cycle();

    // Reset discards a pending writeback.
    reset = 1; W_wrE = 1; W_dstE = 4'd2; W_valE = 64'd99;
    cycle();
    idle_inputs();
    dbg_idx = 4'd2;
    #1 chk("rst_drop", dbg_val, 64'd0);
    cycle();

    // Random traffic with biased register indices to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      reset    = ($urandom_range(0, 59) == 0);
      D_icode  = 4'($urandom_range(0, 15));
      D_ifun   = 4'($urandom_range(0, 15));
      D_rA     = rnd_idx();
      D_rB     = rnd_idx();
      D_valC   = rnd64();
      D_valP   = rnd64();
      D_stat   = 4'($urandom_range(0, 15));
      e_dstE   = rnd_idx(); e_valE = rnd64();
      M_dstE   = rnd_idx(); M_valE = rnd64();
      M_dstM   = rnd_idx(); m_valM = rnd64();
      W_dstE   = rnd_idx(); W_valE = rnd64();
      W_dstM   = rnd_idx(); W_valM = rnd64();
      W_wrE    = 1'($urandom_range(0, 1));
      W_wrM    = 1'($urandom_range(0, 1));
      E_stall  = ($urandom_range(0, 7) == 0);
      E_bubble = ($urandom_range(0, 9) == 0);
      dbg_idx  = 4'($urandom_range(0, 15));
      cycle();
    end

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
